// File: rtl/aes_key_schedule_seq.sv
// Word-serial AES key expansion (AES-128/192/256) with round-key streaming.
// One 32-bit schedule word is produced per cycle and packed into 128-bit round
// keys, which leave under a valid/ready handshake with backpressure.
//
// Ports:
//   clk_i             clock
//   rst_i             synchronous active-high reset
//   start_i           request pulse, sampled only while idle
//   key_mode_i        0=128, 1=192, 2=256, 3=illegal
//   key_in_i          cipher key, w0 in the MSBs, shorter keys left-aligned
//   busy_o            high from start accept through the final round-key handshake
//   err_o             one-cycle pulse on a rejected start
//   rk_valid_o        round key available
//   rk_ready_i        consumer accepts round key
//   rk_data_o         {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   rk_index_o        round number r
//   done_o            one-cycle pulse after the last round key is accepted
//   last_key_o        (AES_KS_LASTKEY_EN) final round key, for decryption
//   last_key_valid_o  (AES_KS_LASTKEY_EN) last_key_o holds a captured key
//
// Optional feature macro: AES_KS_LASTKEY_EN.
module aes_key_schedule_seq #(
    parameter int unsigned MAX_KEY_BITS = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [1:0]              key_mode_i,
    input  logic [MAX_KEY_BITS-1:0] key_in_i,
    output logic                    busy_o,
    output logic                    err_o,
    output logic                    rk_valid_o,
    input  logic                    rk_ready_i,
    output logic [127:0]            rk_data_o,
    output logic [3:0]              rk_index_o,
    output logic                    done_o
`ifdef AES_KS_LASTKEY_EN
    ,
    output logic [127:0]            last_key_o,
    output logic                    last_key_valid_o
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [8:0] MaxBits = 9'(MAX_KEY_BITS);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        logic [7:0] r;
        y = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            y = gf_mul(y, y);
            r = gf_mul(r, y);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    state_e        state_q, state_d;
    logic [31:0]   win_q [8];
    logic [31:0]   win_d [8];
    logic [3:0]    nk_q, nk_d;
    logic [5:0]    i_q, i_d;
    logic [2:0]    pos_q, pos_d;      // i mod Nk, kept as a counter
    logic [7:0]    rcon_q, rcon_d;
    logic [127:0]  pack_q, pack_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [3:0]    idx_q, idx_d;
    logic          err_q, err_d;
`ifdef AES_KS_LASTKEY_EN
    logic [127:0]  last_key_q, last_key_d;
    logic          lkv_q, lkv_d;
`endif

    logic [31:0]   key_words [8];
    logic [8:0]    req_bits;
    logic          mode_ok;
    logic [3:0]    nk_sel;
    logic [2:0]    nk_m1;
    logic [5:0]    total_words;
    logic [3:0]    nr;
    logic [31:0]   prev_word;
    logic [31:0]   temp;
    logic [31:0]   word;
    logic          stall;
    logic          produce;
    logic          handshake;

    always_comb begin
        for (int j = 0; j < 8; j++) key_words[j] = 32'h0;
        for (int j = 0; j < int'(MAX_KEY_BITS / 32); j++) begin
            key_words[j] = key_in_i[MAX_KEY_BITS - 1 - 32 * j -: 32];
        end
    end

    assign req_bits    = 9'd128 + {1'b0, key_mode_i, 6'd0};
    assign mode_ok     = (key_mode_i != 2'd3) && (req_bits <= MaxBits);
    assign nk_sel      = 4'd4 + {1'b0, key_mode_i, 1'b0};
    assign nk_m1       = 3'(nk_q - 4'd1);
    assign total_words = {nk_q, 2'b00} + 6'd28;
    assign nr          = nk_q + 4'd6;
    assign prev_word   = win_q[nk_m1];

    // Window holds w[i-Nk]..w[i-1] in slots 0..Nk-1. While i<Nk it simply rotates,
    // so after Nk key words it is back in order and slot 0 is w[i-Nk].
    always_comb begin
        temp = prev_word;
        if (pos_q == 3'd0) begin
            temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon_q, 24'h0};
        end else if (nk_q == 4'd8 && pos_q == 3'd4) begin
            temp = sub_word(prev_word);
        end
        word = (i_q >= {2'b00, nk_q}) ? (win_q[0] ^ temp) : win_q[0];
    end

    assign stall     = valid_q & ~rk_ready_i;
    assign handshake = valid_q & rk_ready_i;
    assign produce   = (state_q == StRun) && (i_q < total_words) && !stall;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        nk_d    = nk_q;
        i_d     = i_q;
        pos_d   = pos_q;
        rcon_d  = rcon_q;
        pack_d  = pack_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
`ifdef AES_KS_LASTKEY_EN
        last_key_d = last_key_q;
        lkv_d      = lkv_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (mode_ok) begin
                        state_d = StRun;
                        win_d   = key_words;
                        nk_d    = nk_sel;
                        i_d     = 6'd0;
                        pos_d   = 3'd0;
                        rcon_d  = 8'h01;
                        pack_d  = 128'h0;
                        cnt_d   = 2'd0;
                        valid_d = 1'b0;
                        idx_d   = 4'd0;
`ifdef AES_KS_LASTKEY_EN
                        last_key_d = 128'h0;
                        lkv_d      = 1'b0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == nr) begin
                        state_d = StDone;
`ifdef AES_KS_LASTKEY_EN
                        last_key_d = pack_q;
                        lkv_d      = 1'b1;
`endif
                    end
                end
                if (produce) begin
                    // A word entering alongside a handshake starts a fresh group.
                    pack_d = valid_q ? {96'h0, word} : {pack_q[95:0], word};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) valid_d = 1'b1;
                    for (int j = 0; j < 7; j++) win_d[j] = win_q[j + 1];
                    win_d[nk_m1] = word;
                    i_d   = i_q + 6'd1;
                    pos_d = (pos_q == nk_m1) ? 3'd0 : pos_q + 3'd1;
                    if (i_q >= {2'b00, nk_q} && pos_q == 3'd0) rcon_d = xtime(rcon_q);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            for (int j = 0; j < 8; j++) win_q[j] <= 32'h0;
            nk_q    <= 4'd0;
            i_q     <= 6'd0;
            pos_q   <= 3'd0;
            rcon_q  <= 8'h00;
            pack_q  <= 128'h0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            idx_q   <= 4'd0;
            err_q   <= 1'b0;
`ifdef AES_KS_LASTKEY_EN
            last_key_q <= 128'h0;
            lkv_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            for (int j = 0; j < 8; j++) win_q[j] <= win_d[j];
            nk_q    <= nk_d;
            i_q     <= i_d;
            pos_q   <= pos_d;
            rcon_q  <= rcon_d;
            pack_q  <= pack_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
`ifdef AES_KS_LASTKEY_EN
            last_key_q <= last_key_d;
            lkv_q      <= lkv_d;
`endif
        end
    end

    assign busy_o     = (state_q == StRun);
    assign done_o     = (state_q == StDone);
    assign err_o      = err_q;
    assign rk_valid_o = valid_q;
    assign rk_data_o  = pack_q;
    assign rk_index_o = idx_q;
`ifdef AES_KS_LASTKEY_EN
    assign last_key_o       = last_key_q;
    assign last_key_valid_o = lkv_q;
`endif

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed self-checking bench for aes_key_schedule_seq (FIPS-197 vectors).
module tb_aes_key_schedule_seq;

    logic         clk = 1'b0;
    logic         rst, start, start128, rk_ready;
    logic [1:0]   key_mode;
    logic [255:0] key_in;
    logic         busy, err, rk_valid, done;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         busy128, err128, rk_valid128, done128;
    logic [127:0] rk_data128;
    logic [3:0]   rk_index128;
`ifdef AES_KS_LASTKEY_EN
    logic [127:0] last_key, last_key128;
    logic         last_key_valid, last_key_valid128;
`endif

    always #5 clk = ~clk;

    aes_key_schedule_seq #(.MAX_KEY_BITS(256)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .key_mode_i(key_mode), .key_in_i(key_in),
        .busy_o(busy), .err_o(err), .rk_valid_o(rk_valid), .rk_ready_i(rk_ready),
        .rk_data_o(rk_data), .rk_index_o(rk_index), .done_o(done)
`ifdef AES_KS_LASTKEY_EN
        , .last_key_o(last_key), .last_key_valid_o(last_key_valid)
`endif
    );

    aes_key_schedule_seq #(.MAX_KEY_BITS(128)) dut128 (
        .clk_i(clk), .rst_i(rst), .start_i(start128), .key_mode_i(key_mode),
        .key_in_i(key_in[255:128]), .busy_o(busy128), .err_o(err128),
        .rk_valid_o(rk_valid128), .rk_ready_i(1'b1), .rk_data_o(rk_data128),
        .rk_index_o(rk_index128), .done_o(done128)
`ifdef AES_KS_LASTKEY_EN
        , .last_key_o(last_key128), .last_key_valid_o(last_key_valid128)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] keys [16];
    logic [127:0] ref256 [16];
    int nkeys, first_valid_cyc, done_cyc, busy_low, err_seen, stall_bad, idx_bad, valid_cycles;
    logic busy_at_done;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic start_req(input logic [1:0] mode, input logic [255:0] key);
        start    = 1'b1;
        key_mode = mode;
        key_in   = key;
        @(negedge clk);
        start    = 1'b0;
        key_mode = 2'($urandom);
        key_in   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // cyc counts posedges since the accept edge; outputs are sampled at negedges.
    task automatic collect(input bit bp, input int poke_cyc, input int max_cyc);
        int   cyc = 0;
        int   hold = 0;
        bit   stalled = 1'b0;
        bit   rdy;
        logic [127:0] sd = '0;
        logic [3:0]   si = '0;
        nkeys = 0; first_valid_cyc = -1; done_cyc = -1; busy_low = 0; err_seen = 0;
        stall_bad = 0; idx_bad = 0; valid_cycles = 0; busy_at_done = 1'bx;
        while (cyc < max_cyc) begin
            if (stalled && !(rk_valid === 1'b1 && rk_data === sd && rk_index === si)) stall_bad++;
            if (err) err_seen++;
            if (done) begin
                done_cyc = cyc;
                busy_at_done = busy;
                break;
            end
            if (!busy) busy_low++;
            if (rk_valid) valid_cycles++;
            if (rk_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bp) begin
                if (hold > 0) begin
                    hold--;
                    rdy = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    hold = 9;
                    rdy = 1'b0;
                end else begin
                    rdy = 1'($urandom_range(0, 1));
                end
            end else begin
                rdy = 1'b1;
            end
            rk_ready = rdy;
            start    = (cyc == poke_cyc);
            if (cyc == poke_cyc) key_mode = 2'd0;
            if (rk_valid && rdy) begin
                if (rk_index !== 4'(nkeys)) idx_bad++;
                if (nkeys < 16) keys[nkeys] = rk_data;
                nkeys++;
            end
            stalled = rk_valid && !rdy;
            sd = rk_data;
            si = rk_index;
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        rk_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start128 = 1'b0; rk_ready = 1'b1;
        key_mode = 2'd0; key_in = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_outs", {rk_data, 4'h0}, 128'h0);
        check("reset_misc", 128'({err, rk_valid, rk_index, done}), 128'h0);
        rst = 1'b0;
        @(negedge clk);

        // AES-128, no backpressure
        start_req(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        collect(1'b0, -1, 200);
        check("a128_first_valid", 128'(first_valid_cyc), 128'd4);
        check("a128_nkeys", 128'(nkeys), 128'd11);
        check("a128_valid_cycles", 128'(valid_cycles), 128'd11);
        check("a128_rk0", keys[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("a128_rk1", keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("a128_rk2", keys[2], 128'hf2c295f27a96b9435935807a7359f67f);
        check("a128_rk10", keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("a128_idx", 128'(idx_bad), 128'd0);
        check("a128_done_cyc", 128'(done_cyc), 128'd45);
        check("a128_busy_run", 128'(busy_low), 128'd0);
        check("a128_busy_done", 128'(busy_at_done), 128'd0);
        @(negedge clk);
        check("a128_done_pulse", 128'(done), 128'd0);

        // AES-192
        start_req(2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
        collect(1'b0, -1, 200);
        check("a192_nkeys", 128'(nkeys), 128'd13);
        check("a192_rk0", keys[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
        check("a192_rk1", keys[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        check("a192_w51", 128'(keys[12][31:0]), 128'h01002202);
        check("a192_done_cyc", 128'(done_cyc), 128'd53);
        @(negedge clk);

        // AES-256, no backpressure, kept as the reference sequence
        start_req(2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        collect(1'b0, -1, 200);
        check("a256_nkeys", 128'(nkeys), 128'd15);
        check("a256_rk1", keys[1], 128'h1f352c073b6108d72d9810a30914dff4);
        check("a256_rk2", keys[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        check("a256_rk14", keys[14], 128'hfe4890d1e6188d0b046df344706c631e);
        check("a256_done_cyc", 128'(done_cyc), 128'd61);
`ifdef AES_KS_LASTKEY_EN
        check("a256_last_key", last_key, 128'hfe4890d1e6188d0b046df344706c631e);
        check("a256_last_key_valid", 128'(last_key_valid), 128'd1);
`endif
        for (int k = 0; k < 16; k++) ref256[k] = keys[k];
        @(negedge clk);

        // AES-256 with random backpressure
        start_req(2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        collect(1'b1, -1, 2000);
        check("bp_nkeys", 128'(nkeys), 128'd15);
        check("bp_stall_stable", 128'(stall_bad), 128'd0);
        check("bp_idx", 128'(idx_bad), 128'd0);
        for (int k = 0; k < 15; k++) check($sformatf("bp_rk%0d", k), keys[k], ref256[k]);
        check("bp_done_seen", 128'(done_cyc > 0), 128'd1);
        @(negedge clk);

        // Illegal mode rejected
        start_req(2'd3, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        check("rej_err", 128'(err), 128'd1);
        check("rej_busy", 128'(busy), 128'd0);
        @(negedge clk);
        check("rej_err_pulse", 128'(err), 128'd0);
        check("rej_busy2", 128'(busy), 128'd0);

        // Key size above MAX_KEY_BITS rejected
        start128 = 1'b1; key_mode = 2'd2; key_in = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        @(negedge clk);
        start128 = 1'b0;
        check("max128_err", 128'(err128), 128'd1);
        check("max128_busy", 128'(busy128), 128'd0);
        check("max128_main_idle", 128'({busy, err}), 128'd0);
        @(negedge clk);

        // start during RUN ignored
        start_req(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        collect(1'b0, 6, 200);
        check("ign_err", 128'(err_seen), 128'd0);
        check("ign_nkeys", 128'(nkeys), 128'd11);
        check("ign_rk1", keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("ign_done_cyc", 128'(done_cyc), 128'd45);
        @(negedge clk);

        // Reset in round 5 of AES-128
        start_req(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        rk_ready = 1'b1;
        begin
            int w = 0;
            while (rk_index !== 4'd5 && w < 100) begin
                @(negedge clk);
                w++;
            end
            check("rst_reached_r5", 128'(rk_index), 128'd5);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_outs", rk_data, 128'h0);
        check("rst_misc", 128'({busy, err, rk_valid, rk_index, done}), 128'h0);
`ifdef AES_KS_LASTKEY_EN
        check("rst_lkv", 128'(last_key_valid), 128'd0);
`endif
        begin
            int dn = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (done || busy) dn++;
            end
            check("rst_quiet", 128'(dn), 128'd0);
        end
        start_req(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        collect(1'b0, -1, 200);
        check("rst_restart_rk1", keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("rst_restart_nkeys", 128'(nkeys), 128'd11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule_seq.md
Name: aes_key_schedule_seq

Overview:
- Word-serial AES key expansion for AES-128, AES-192 and AES-256, with key size selected per request.
- Loads a cipher key on a start pulse, generates one 32-bit schedule word per cycle, and packs the words into 128-bit round keys.
- Round keys are streamed out under a valid/ready handshake with backpressure. It sits between the key register file and the round datapath.
- Uses internal combinational S-box logic and generates Rcon internally; there is no external Rcon input.

Parameters:
- MAX_KEY_BITS, 256, largest key size supported (128, 192 or 256). Modes above it are rejected.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse; sampled only in IDLE
- key_mode  in  2  0=128, 1=192, 2=256, 3=illegal
- key_in  in  MAX_KEY_BITS  key; word w0 in the MSBs, FIPS-197 byte order; shorter keys are left-aligned
- busy  out  1  high from start accept through final round-key handshake
- err  out  1  one-cycle pulse on a rejected start
- rk_valid  out  1  round key available
- rk_ready  in  1  consumer accepts round key
- rk_data  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96]
- rk_index  out  4  round number r, 0..Nr
- done  out  1  one-cycle pulse after last round key accepted

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Word window, packer, word counter and Rcon cleared.
  - rst overrides everything, including mid-run; no done pulse after reset.
- Key sizes:
  - Nk = 4/6/8, Nr = 10/12/14.
  - Total words 44/52/60; round keys 11/13/15.
- FSM states:
  - IDLE --start & legal mode--> RUN.
  - IDLE --start & (mode==3 or key bits > MAX_KEY_BITS)--> IDLE, err=1 for one cycle.
  - RUN --last round key handshake--> DONE.
  - DONE --> IDLE, done=1 for one cycle.
- On accept: latch the Nk key words into the window and Nk into the mode register, set word counter i=0, set Rcon=0x01.
- RUN, per cycle when not stalled: word i enters the packer, then i increments.
  - For i<Nk: word = key word i.
  - Otherwise: w[i] = w[i-Nk] ^ temp, where temp = w[i-1], with these modifications:
    - i mod Nk == 0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}; then Rcon = xtime(Rcon) (0x1b reduction).
    - Nk==8 and i mod 8 == 4: temp = SubWord(w[i-1]).
  - The window shifts by one word each time a word is produced.
- Stall rule:
  - Stalled when rk_valid=1 and rk_ready=0. A stall freezes i, the window, Rcon and rk_data.
  - When rk_valid & rk_ready, the packer empties and the next word may enter on the same edge.
- Handshake:
  - rk_valid rises once the 4th word of a group is packed.
  - rk_valid, rk_data and rk_index stay stable until accepted.
  - rk_index increments on each handshake.
- Latency:
  - The first rk_valid appears 4 cycles after the start-accept edge.
  - With rk_ready tied high: one round key every 4 cycles, rk_valid high one cycle each time.
  - Last round key appears 4·(Nr+1) cycles after accept.
  - done is asserted the cycle after the final handshake; busy falls on that same edge.
- start during RUN/DONE is ignored: no err, no restart.
- key_in and key_mode are don't-care after accept.

Optional Feature:
- Macro: AES_KS_LASTKEY_EN.
- When defined:
  - Adds output last_key (128) and last_key_valid (1).
  - last_key captures the final round key (index Nr) on its handshake and holds it until the next start accept or rst.
  - last_key_valid is set with the capture and cleared on start accept or rst.
  - Intended as the decryption starting key.
- When undefined: the ports and registers are absent; all other behaviour is identical.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk1=a0fafe1788542cb123a339392a6c7605; rk10=d014f9a8c9ee2589e13f0cc8b6630ca6 at index 10; 11 keys total; done 45 cycles after accept.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk1=62f8ead2522c6b7bfe0c91f72402f5a5; last word w51=01002202; 13 keys.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk2=9ba354118e6925afa51a8b5f2067fcde; rk14=fe4890d1e6188d0b046df344706c631e.
- Backpressure: rk_ready randomly low (including 10-cycle holds) on AES-256 -> rk_data/rk_index stable while stalled; sequence identical to the unstalled run; no dropped or duplicated index.
- Rejects: key_mode=3 -> err pulse, busy stays 0. start during RUN -> ignored. With MAX_KEY_BITS=128 and key_mode=2 -> err.
- rst asserted at round 5 of AES-128 -> next cycle all outputs 0 and FSM in IDLE; a new start reproduces rk1 correctly. With AES_KS_LASTKEY_EN, last_key_valid=0 after rst.
